// File: rtl/wb_scoreboard_pkg.sv
// Shared constants and types for the long-latency scoreboard and its
// writeback-port arbiter.
package wb_scoreboard_pkg;

  localparam int         XLEN_DEFAULT = 32;
  localparam logic [4:0] REG_X0       = 5'd0;

  typedef enum logic {
    ARB_NORMAL = 1'b0,
    ARB_FORCE  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: the pipeline normally wins, and the long
// unit is forced onto the port for one cycle after a run of denied cycles.
module wb_arbiter
  import wb_scoreboard_pkg::*;
#(
  parameter int XLEN         = XLEN_DEFAULT,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            lu_wb_valid,
  input  logic [4:0]      lu_wb_rd,
  input  logic [XLEN-1:0] lu_wb_data,
  output logic            lu_wb_ready,
  output logic            pipe_wb_stall,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata
);

  localparam int SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT - 1);

  arb_state_e    state, state_next;
  logic [SW-1:0] starve_cnt, starve_cnt_next;
  logic          grant_lu;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ARB_NORMAL;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_cnt_next;
    end
  end

  // The forced cycle is taken even if the long unit has dropped its request;
  // the port then simply idles for that cycle.
  always_comb begin
    state_next      = state;
    starve_cnt_next = '0;
    grant_lu        = 1'b0;
    lu_wb_ready     = 1'b0;
    pipe_wb_stall   = 1'b0;
    rf_we           = 1'b0;
    rf_waddr        = '0;
    rf_wdata        = '0;

    if (state == ARB_FORCE) begin
      grant_lu      = 1'b1;
      lu_wb_ready   = lu_wb_valid;
      pipe_wb_stall = 1'b1;
      state_next    = ARB_NORMAL;
    end else begin
      grant_lu    = !wb_valid;
      lu_wb_ready = !wb_valid && lu_wb_valid;
      if (wb_valid && lu_wb_valid) begin
        if (starve_cnt == STARVE_MAX) begin
          state_next = ARB_FORCE;
        end else begin
          starve_cnt_next = starve_cnt + 1'b1;
        end
      end
    end

    if (grant_lu) begin
      rf_we    = lu_wb_valid && (lu_wb_rd != REG_X0);
      rf_waddr = lu_wb_rd;
      rf_wdata = lu_wb_data;
    end else begin
      rf_we    = wb_valid && (wb_rd != REG_X0);
      rf_waddr = wb_rd;
      rf_wdata = wb_data;
    end

    if (!reset_n) begin
      lu_wb_ready   = 1'b0;
      pipe_wb_stall = 1'b0;
      rf_we         = 1'b0;
      rf_waddr      = '0;
      rf_wdata      = '0;
    end
  end

endmodule

// File: rtl/wb_scoreboard.sv
// Scoreboard for long-latency ops: tracks pending destinations, stalls decode
// on hazards and shares the register-file write port with the pipeline.
module wb_scoreboard
  import wb_scoreboard_pkg::*;
#(
  parameter int XLEN            = XLEN_DEFAULT,
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            de_valid,
  input  logic [4:0]      de_rs1,
  input  logic [4:0]      de_rs2,
  input  logic [4:0]      de_rd,
  input  logic            de_long,
  output logic            sb_stall,
  input  logic            lu_issue_valid,
  input  logic [4:0]      lu_issue_rd,
  output logic            lu_issue_ready,
  input  logic            lu_wb_valid,
  input  logic [4:0]      lu_wb_rd,
  input  logic [XLEN-1:0] lu_wb_data,
  output logic            lu_wb_ready,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            pipe_wb_stall,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTSTANDING);

  logic [31:1]   busy, busy_next;
  logic [31:0]   busy_vec;
  logic [OW-1:0] outstanding, outstanding_next;
  logic          full, issue_fire, lu_fire;

  // x0 is hard-wired as never busy so indexing by any 5-bit register is safe.
  assign busy_vec = {busy, 1'b0};
  assign full     = (outstanding == OUT_MAX);

  assign lu_issue_ready = reset_n && !full;
  assign sb_stall = reset_n && de_valid &&
                    (busy_vec[de_rs1] || busy_vec[de_rs2] || busy_vec[de_rd] ||
                     (de_long && full));

  assign issue_fire = lu_issue_valid && lu_issue_ready;
  assign lu_fire    = lu_wb_valid && lu_wb_ready;

  wb_arbiter #(
    .XLEN         (XLEN),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arbiter (
    .clk           (clk),
    .reset_n       (reset_n),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .lu_wb_valid   (lu_wb_valid),
    .lu_wb_rd      (lu_wb_rd),
    .lu_wb_data    (lu_wb_data),
    .lu_wb_ready   (lu_wb_ready),
    .pipe_wb_stall (pipe_wb_stall),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata)
  );

  // Issue is applied after the writeback clear so a same-register pair leaves
  // the register pending on the new op.
  always_comb begin
    busy_next = busy;
    if (lu_fire && (lu_wb_rd != REG_X0)) begin
      busy_next[lu_wb_rd] = 1'b0;
    end
    if (issue_fire && (lu_issue_rd != REG_X0)) begin
      busy_next[lu_issue_rd] = 1'b1;
    end
  end

  always_comb begin
    outstanding_next = outstanding;
    case ({issue_fire, lu_fire})
      2'b10:   outstanding_next = outstanding + 1'b1;
      2'b01:   outstanding_next = outstanding - 1'b1;
      default: outstanding_next = outstanding;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy        <= '0;
      outstanding <= '0;
    end else begin
      busy        <= busy_next;
      outstanding <= outstanding_next;
    end
  end

`ifndef SYNTHESIS
  a_lu_wb_busy: assert property (@(posedge clk) disable iff (!reset_n)
    (lu_fire && (lu_wb_rd != REG_X0)) |-> busy_vec[lu_wb_rd]);

  a_pipe_wb_busy: assert property (@(posedge clk) disable iff (!reset_n)
    (wb_valid && !pipe_wb_stall && (wb_rd != REG_X0)) |-> !busy_vec[wb_rd]);

  a_issue_full: assert property (@(posedge clk) disable iff (!reset_n)
    lu_issue_valid |-> !full);

  a_underflow: assert property (@(posedge clk) disable iff (!reset_n)
    (lu_fire && !issue_fire) |-> (outstanding != '0));
`endif

endmodule

// File: tb/tb_wb_scoreboard.sv
// Self-checking bench for wb_scoreboard: per-feature tasks plus a queue of
// expected register-file writes checked by a write-port monitor.
module tb_wb_scoreboard;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        de_valid = 1'b0, de_long = 1'b0;
  logic [4:0]  de_rs1 = '0, de_rs2 = '0, de_rd = '0;
  logic        sb_stall;
  logic        lu_issue_valid = 1'b0;
  logic [4:0]  lu_issue_rd = '0;
  logic        lu_issue_ready;
  logic        lu_wb_valid = 1'b0;
  logic [4:0]  lu_wb_rd = '0;
  logic [31:0] lu_wb_data = '0;
  logic        lu_wb_ready;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        pipe_wb_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  tests_run = 0;
  int  tests_failed = 0;

  wb_scoreboard #(.XLEN(32), .MAX_OUTSTANDING(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .de_valid(de_valid), .de_rs1(de_rs1), .de_rs2(de_rs2), .de_rd(de_rd),
    .de_long(de_long), .sb_stall(sb_stall),
    .lu_issue_valid(lu_issue_valid), .lu_issue_rd(lu_issue_rd),
    .lu_issue_ready(lu_issue_ready),
    .lu_wb_valid(lu_wb_valid), .lu_wb_rd(lu_wb_rd), .lu_wb_data(lu_wb_data),
    .lu_wb_ready(lu_wb_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .pipe_wb_stall(pipe_wb_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  // Every write seen on the port must match the oldest expected write.
  always @(negedge clk) begin
    if (reset_n && rf_we) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL unexpected_write got addr=%0d data=%h, none expected", rf_waddr, rf_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (rf_waddr !== mon_e.addr || rf_wdata !== mon_e.data) begin
          tests_failed++;
          $display("[TB] FAIL rf_write got addr=%0d data=%h, exp addr=%0d data=%h",
                   rf_waddr, rf_wdata, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    de_valid = 1'b1; de_rs1 = 5'd5; de_rs2 = 5'd6; de_rd = 5'd7;
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hCAFE_0003;
    lu_wb_valid = 1'b1; lu_wb_rd = 5'd4; lu_wb_data = 32'hBEEF_0004;
    #12;
    tests_run++;
    if ({sb_stall, lu_issue_ready, lu_wb_ready, pipe_wb_stall, rf_we, rf_waddr, rf_wdata} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs got stall=%b ir=%b lr=%b ps=%b we=%b a=%0d d=%h, exp all 0",
               sb_stall, lu_issue_ready, lu_wb_ready, pipe_wb_stall, rf_we, rf_waddr, rf_wdata);
    end
    wb_valid = 1'b0; lu_wb_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    next_cycle();
    @(negedge clk);
    tests_run++;
    if (sb_stall !== 1'b0 || lu_issue_ready !== 1'b1 || rf_we !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL post_reset got stall=%b ready=%b we=%b, exp 0 1 0", sb_stall, lu_issue_ready, rf_we);
    end
    next_cycle();
    de_valid = 1'b0;
  endtask

  task automatic test_raw_hazard();
    lu_issue_valid = 1'b1; lu_issue_rd = 5'd5;
    next_cycle();
    lu_issue_valid = 1'b0;
    de_valid = 1'b1; de_rs1 = 5'd5; de_rs2 = 5'd0; de_rd = 5'd0; de_long = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests_run++;
      if (sb_stall !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL raw_stall got %b, exp 1", sb_stall);
      end
      next_cycle();
    end
    lu_wb_valid = 1'b1; lu_wb_rd = 5'd5; lu_wb_data = 32'h0000_1234;
    expect_write(5'd5, 32'h0000_1234);
    @(negedge clk);
    tests_run++;
    if (lu_wb_ready !== 1'b1 || sb_stall !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL raw_wb_cycle got ready=%b stall=%b, exp 1 1", lu_wb_ready, sb_stall);
    end
    next_cycle();
    lu_wb_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (sb_stall !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL raw_release got %b, exp 0", sb_stall);
    end
    next_cycle();
    de_valid = 1'b0;
  endtask

  task automatic test_outstanding();
    lu_issue_valid = 1'b1; lu_issue_rd = 5'd3;
    next_cycle();
    lu_issue_rd = 5'd4;
    next_cycle();
    lu_issue_valid = 1'b0;
    de_valid = 1'b1; de_long = 1'b1; de_rs1 = 5'd0; de_rs2 = 5'd0; de_rd = 5'd9;
    @(negedge clk);
    tests_run++;
    if (lu_issue_ready !== 1'b0 || sb_stall !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL full_long got ready=%b stall=%b, exp 0 1", lu_issue_ready, sb_stall);
    end
    next_cycle();
    de_long = 1'b0;
    @(negedge clk);
    tests_run++;
    if (sb_stall !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL full_short got stall=%b, exp 0", sb_stall);
    end
    next_cycle();
    de_valid = 1'b0;
    lu_wb_valid = 1'b1; lu_wb_rd = 5'd3; lu_wb_data = 32'h0000_3333;
    expect_write(5'd3, 32'h0000_3333);
    @(negedge clk);
    tests_run++;
    if (lu_issue_ready !== 1'b0 || lu_wb_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL full_wb got ready=%b lu_ready=%b, exp 0 1", lu_issue_ready, lu_wb_ready);
    end
    next_cycle();
    lu_wb_rd = 5'd4; lu_wb_data = 32'h0000_4444;
    expect_write(5'd4, 32'h0000_4444);
    @(negedge clk);
    tests_run++;
    if (lu_issue_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL slot_freed got ready=%b, exp 1", lu_issue_ready);
    end
    next_cycle();
    lu_wb_valid = 1'b0;
  endtask

  task automatic test_starvation();
    lu_issue_valid = 1'b1; lu_issue_rd = 5'd10;
    next_cycle();
    lu_issue_valid = 1'b0;
    lu_wb_valid = 1'b1; lu_wb_rd = 5'd10; lu_wb_data = 32'hAAAA_0010;
    wb_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wb_rd = 5'(11 + i); wb_data = 32'h0000_1000 + 32'(i);
      expect_write(wb_rd, wb_data);
      @(negedge clk);
      tests_run++;
      if (pipe_wb_stall !== 1'b0 || lu_wb_ready !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL starve_pipe%0d got ps=%b lr=%b, exp 0 0", i, pipe_wb_stall, lu_wb_ready);
      end
      next_cycle();
    end
    wb_rd = 5'd15; wb_data = 32'h0000_1004;
    expect_write(5'd10, 32'hAAAA_0010);
    @(negedge clk);
    tests_run++;
    if (pipe_wb_stall !== 1'b1 || lu_wb_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL force_cycle got ps=%b lr=%b, exp 1 1", pipe_wb_stall, lu_wb_ready);
    end
    next_cycle();
    lu_wb_valid = 1'b0;
    expect_write(5'd15, 32'h0000_1004);
    @(negedge clk);
    tests_run++;
    if (pipe_wb_stall !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL force_resume got ps=%b, exp 0", pipe_wb_stall);
    end
    next_cycle();
    wb_valid = 1'b0;
  endtask

  task automatic test_starve_clear();
    lu_issue_valid = 1'b1; lu_issue_rd = 5'd16;
    next_cycle();
    lu_issue_valid = 1'b0;
    lu_wb_valid = 1'b1; lu_wb_rd = 5'd16; lu_wb_data = 32'h1616_1616;
    wb_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      lu_wb_valid = (i != 3);
      wb_rd = 5'(17 + i); wb_data = 32'h5000_0000 + 32'(i);
      expect_write(wb_rd, wb_data);
      @(negedge clk);
      tests_run++;
      if (pipe_wb_stall !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL clear_pipe%0d got ps=%b, exp 0", i, pipe_wb_stall);
      end
      next_cycle();
    end
    wb_valid = 1'b0;
    expect_write(5'd16, 32'h1616_1616);
    @(negedge clk);
    tests_run++;
    if (lu_wb_ready !== 1'b1 || pipe_wb_stall !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL idle_grant got lr=%b ps=%b, exp 1 0", lu_wb_ready, pipe_wb_stall);
    end
    next_cycle();
    lu_wb_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    lu_issue_valid = 1'b1; lu_issue_rd = 5'd8;
    next_cycle();
    lu_wb_valid = 1'b1; lu_wb_rd = 5'd8; lu_wb_data = 32'h0000_8888;
    expect_write(5'd8, 32'h0000_8888);
    @(negedge clk);
    tests_run++;
    if (lu_issue_ready !== 1'b1 || lu_wb_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL same_cycle got ir=%b lr=%b, exp 1 1", lu_issue_ready, lu_wb_ready);
    end
    next_cycle();
    lu_issue_valid = 1'b0; lu_wb_valid = 1'b0;
    de_valid = 1'b1; de_rs1 = 5'd0; de_rs2 = 5'd0; de_rd = 5'd8;
    @(negedge clk);
    tests_run++;
    if (sb_stall !== 1'b1 || lu_issue_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL issue_wins got stall=%b ready=%b, exp 1 1", sb_stall, lu_issue_ready);
    end
    next_cycle();
    de_valid = 1'b0;
    lu_issue_valid = 1'b1; lu_issue_rd = 5'd0;
    next_cycle();
    lu_issue_valid = 1'b0;
    lu_wb_valid = 1'b1; lu_wb_rd = 5'd0; lu_wb_data = 32'hDEAD_0000;
    @(negedge clk);
    tests_run++;
    if (lu_issue_ready !== 1'b0 || rf_we !== 1'b0 || lu_wb_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL x0_wb got ir=%b we=%b lr=%b, exp 0 0 1", lu_issue_ready, rf_we, lu_wb_ready);
    end
    next_cycle();
    lu_wb_rd = 5'd8; lu_wb_data = 32'h0000_0808;
    expect_write(5'd8, 32'h0000_0808);
    @(negedge clk);
    tests_run++;
    if (lu_issue_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL x0_decrement got ready=%b, exp 1", lu_issue_ready);
    end
    next_cycle();
    lu_wb_valid = 1'b0;
    de_valid = 1'b1; de_rd = 5'd8;
    @(negedge clk);
    tests_run++;
    if (sb_stall !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL r8_released got stall=%b, exp 0", sb_stall);
    end
    next_cycle();
    de_valid = 1'b0;
  endtask

  task automatic test_reset_midop();
    lu_issue_valid = 1'b1; lu_issue_rd = 5'd20;
    next_cycle();
    lu_issue_rd = 5'd21;
    next_cycle();
    lu_issue_valid = 1'b0;
    lu_wb_valid = 1'b1; lu_wb_rd = 5'd20; lu_wb_data = 32'h2020_2020;
    wb_valid = 1'b1; wb_rd = 5'd22;
    for (int i = 0; i < 4; i++) begin
      wb_data = 32'h0000_2200 + 32'(i);
      expect_write(5'd22, wb_data);
      next_cycle();
    end
    de_valid = 1'b1; de_rs1 = 5'd20; de_rs2 = 5'd21; de_rd = 5'd22;
    #1;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({sb_stall, lu_issue_ready, lu_wb_ready, pipe_wb_stall, rf_we, rf_waddr, rf_wdata} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL midop_reset got stall=%b ir=%b lr=%b ps=%b we=%b a=%0d d=%h, exp all 0",
               sb_stall, lu_issue_ready, lu_wb_ready, pipe_wb_stall, rf_we, rf_waddr, rf_wdata);
    end
    lu_wb_valid = 1'b0; wb_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    next_cycle();
    @(negedge clk);
    tests_run++;
    if (sb_stall !== 1'b0 || lu_issue_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL midop_release got stall=%b ready=%b, exp 0 1", sb_stall, lu_issue_ready);
    end
    next_cycle();
    de_valid = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'h0000_0101;
    expect_write(5'd1, 32'h0000_0101);
    @(negedge clk);
    tests_run++;
    if (pipe_wb_stall !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midop_fsm got ps=%b, exp 0", pipe_wb_stall);
    end
    next_cycle();
    wb_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_raw_hazard();
    test_outstanding();
    test_starvation();
    test_starve_clear();
    test_back_to_back();
    test_reset_midop();
    repeat (2) next_cycle();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL missing_writes got %0d pending, exp 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
